// File: rtl/octal_key_scanner.sv
// Octal key scanner: synchronizes and debounces eight raw key levels and issues
// exactly one registered one-hot symbol per press over a valid/ready handshake.
module octal_key_scanner #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] key_raw,
   input  logic       sym_ready,
   output logic       O0,
   output logic       O1,
   output logic       O2,
   output logic       O3,
   output logic       O4,
   output logic       O5,
   output logic       O6,
   output logic       O7,
   output logic       sym_valid,
   output logic       multi_err
);

   localparam logic [9:0] CNT_LAST = 10'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, OFFER, RELEASE} state_t;

   logic [7:0] sync_a, sync_b, deb;
   logic [9:0] cnt [8];
   state_t     state, state_nxt;
   logic [7:0] sym, sym_nxt;
   logic       valid_nxt, err_nxt;
   logic       deb_one, deb_multi;

   // NOTE: sequential state always uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= key_raw;
         sync_b <= sync_a;
      end
   end

   // NOTE: the counter array is cleared in reset as well, so a key held across
   // reset restarts its full debounce window instead of resuming a stale count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         deb <= '0;
         for (int n = 0; n < 8; n++) cnt[n] <= '0;
      end else begin
         for (int n = 0; n < 8; n++) begin
            if (sync_b[n] == deb[n]) begin
               cnt[n] <= '0;
            end else if (cnt[n] == CNT_LAST) begin
               deb[n] <= sync_b[n];
               cnt[n] <= '0;
            end else begin
               cnt[n] <= cnt[n] + 10'd1;
            end
         end
      end
   end

   // More than one bit set exactly when clearing the lowest set bit leaves any.
   assign deb_multi = |(deb & (deb - 8'd1));
   assign deb_one   = (deb != 8'd0) && !deb_multi;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         sym       <= '0;
         sym_valid <= 1'b0;
         multi_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         sym       <= sym_nxt;
         sym_valid <= valid_nxt;
         multi_err <= err_nxt;
      end
   end

   // NOTE: every variable gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      sym_nxt   = sym;
      valid_nxt = sym_valid;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            sym_nxt   = '0;
            valid_nxt = 1'b0;
            if (deb_one) begin
               sym_nxt   = deb;
               valid_nxt = 1'b1;
               state_nxt = OFFER;
            end else if (deb_multi) begin
               err_nxt   = 1'b1;
               state_nxt = RELEASE;
            end
         end
         OFFER: begin
            // deb is ignored here: the offered symbol holds until consumed.
            if (sym_ready) begin
               sym_nxt   = '0;
               valid_nxt = 1'b0;
               state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            sym_nxt   = '0;
            valid_nxt = 1'b0;
            if (deb == 8'd0) state_nxt = IDLE;
         end
         default: begin
            sym_nxt   = '0;
            valid_nxt = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign {O7, O6, O5, O4, O3, O2, O1, O0} = sym;

endmodule

// File: tb/tb_octal_key_scanner.sv
// Testbench for octal_key_scanner: directed scenarios plus random key traffic,
// all compared cycle by cycle against a window-based behavioural model.
module tb_octal_key_scanner;

   localparam int D = 4;
   localparam int PH_WAIT = 0, PH_HELD = 1, PH_DRAIN = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] key_raw;
   logic       sym_ready;
   logic       O0, O1, O2, O3, O4, O5, O6, O7;
   logic       sym_valid, multi_err;
   logic [7:0] o_vec;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [7:0] hist [$];
   logic [7:0] m_deb, m_sym;
   logic       m_valid, m_err;
   int         m_phase;

   octal_key_scanner #(.DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .sym_ready(sym_ready),
      .O0(O0), .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5), .O6(O6), .O7(O7),
      .sym_valid(sym_valid), .multi_err(multi_err)
   );

   assign o_vec = {O7, O6, O5, O4, O3, O2, O1, O0};

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // A key's debounced level flips once the D most recent synchronized samples
   // (raw samples two edges old and older) all disagree with it.
   function automatic void model_edge(input logic [7:0] raw, input logic rst, input logic ready);
      logic [7:0] deb_old;
      logic       flip;
      deb_old = m_deb;
      if (!rst) begin
         hist.delete();
         for (int j = 0; j < D + 2; j++) hist.push_back(8'h00);
         m_deb = '0; m_sym = '0; m_valid = 1'b0; m_err = 1'b0; m_phase = PH_WAIT;
         return;
      end
      hist.push_back(raw);
      void'(hist.pop_front());
      m_err = 1'b0;
      case (m_phase)
         PH_WAIT: begin
            if ($countones(deb_old) == 1) begin
               m_sym = deb_old; m_valid = 1'b1; m_phase = PH_HELD;
            end else if ($countones(deb_old) > 1) begin
               m_err = 1'b1; m_phase = PH_DRAIN;
            end
         end
         PH_HELD: if (ready) begin
            m_sym = '0; m_valid = 1'b0; m_phase = PH_DRAIN;
         end
         default: if (deb_old == 8'd0) m_phase = PH_WAIT;
      endcase
      for (int n = 0; n < 8; n++) begin
         flip = 1'b1;
         for (int j = 0; j < D; j++) if (hist[j][n] == deb_old[n]) flip = 1'b0;
         if (flip) m_deb[n] = ~deb_old[n];
      end
   endfunction

   task automatic tick();
      logic [7:0] r;
      logic       rs, rd;
      r = key_raw; rs = rst_n; rd = sym_ready;
      @(posedge clk);
      #1;
      model_edge(r, rs, rd);
   endtask

   task automatic test_reset();
      logic ev;
      rst_n = 1'b0; key_raw = 8'h08; sym_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({multi_err, sym_valid, o_vec} !== 10'h000) begin
            errors++;
            $display("FAIL reset_edge%0d got err=%b vld=%b sym=%h exp all 0", i, multi_err, sym_valid, o_vec);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i <= D + 2; i++) begin
         tick();
         ev = (i == D + 2);
         checks++;
         if (sym_valid !== ev || o_vec !== (ev ? 8'h08 : 8'h00)) begin
            errors++;
            $display("FAIL reset_latency i=%0d got vld=%b sym=%h exp vld=%b", i, sym_valid, o_vec, ev);
         end
      end
      sym_ready = 1'b1;
      tick();
      sym_ready = 1'b0; key_raw = 8'h00;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if ({multi_err, sym_valid, o_vec} !== {m_err, m_valid, m_sym}) begin
            errors++;
            $display("FAIL reset_model got %b/%b/%h exp %b/%b/%h", multi_err, sym_valid, o_vec, m_err, m_valid, m_sym);
         end
      end
   endtask

   task automatic test_single_press();
      logic ev;
      int   vcount;
      key_raw = 8'h20; sym_ready = 1'b0;
      for (int i = 0; i < 27; i++) begin
         tick();
         ev = (i >= 6);
         checks++;
         if (sym_valid !== ev || o_vec !== (ev ? 8'h20 : 8'h00) || multi_err !== 1'b0) begin
            errors++;
            $display("FAIL press_timing i=%0d got vld=%b sym=%h exp vld=%b", i, sym_valid, o_vec, ev);
         end
      end
      sym_ready = 1'b1;
      tick();
      sym_ready = 1'b0;
      checks++;
      if (sym_valid !== 1'b0 || o_vec !== 8'h00) begin
         errors++;
         $display("FAIL press_handshake got vld=%b sym=%h exp 0/00", sym_valid, o_vec);
      end
      vcount = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (sym_valid) vcount++;
         checks++;
         if ({multi_err, sym_valid, o_vec} !== {m_err, m_valid, m_sym}) begin
            errors++;
            $display("FAIL press_model got %b/%b/%h exp %b/%b/%h", multi_err, sym_valid, o_vec, m_err, m_valid, m_sym);
         end
      end
      checks++;
      if (vcount !== 0) begin
         errors++;
         $display("FAIL press_no_repeat got %0d valid cycles exp 0", vcount);
      end
      key_raw = 8'h00;
      for (int i = 0; i < 12; i++) tick();
   endtask

   task automatic test_bounce();
      int         vcount, ecount;
      logic [7:0] seen;
      vcount = 0; ecount = 0; seen = 8'h00;
      sym_ready = 1'b1;
      for (int c = 0; c < 37; c++) begin
         key_raw = (c >= 12 || ((c / 2) % 2) == 0) ? 8'h04 : 8'h00;
         tick();
         if (sym_valid) begin vcount++; seen = o_vec; end
         checks++;
         if ({multi_err, sym_valid, o_vec} !== {m_err, m_valid, m_sym}) begin
            errors++;
            $display("FAIL bounce_model c=%0d got %b/%b/%h exp %b/%b/%h", c, multi_err, sym_valid, o_vec, m_err, m_valid, m_sym);
         end
      end
      checks++;
      if (vcount !== 1 || seen !== 8'h04) begin
         errors++;
         $display("FAIL bounce_symbol got %0d symbols last=%h exp 1 symbol 04", vcount, seen);
      end
      key_raw = 8'h00;
      for (int i = 0; i < 12; i++) tick();
      vcount = 0;
      for (int c = 0; c < 18; c++) begin
         key_raw = (c < 3) ? 8'h40 : 8'h00;
         tick();
         if (sym_valid) vcount++;
         if (multi_err) ecount++;
      end
      checks++;
      if (vcount !== 0 || ecount !== 0) begin
         errors++;
         $display("FAIL glitch got %0d symbols %0d errs exp 0 and 0", vcount, ecount);
      end
      sym_ready = 1'b0;
   endtask

   task automatic test_multi();
      int   vcount, ecount;
      logic got;
      vcount = 0; ecount = 0; got = 1'b0;
      key_raw = 8'h11; sym_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (sym_valid) vcount++;
         if (multi_err) ecount++;
         checks++;
         if ({multi_err, sym_valid, o_vec} !== {m_err, m_valid, m_sym}) begin
            errors++;
            $display("FAIL multi_model got %b/%b/%h exp %b/%b/%h", multi_err, sym_valid, o_vec, m_err, m_valid, m_sym);
         end
      end
      checks++;
      if (ecount !== 1 || vcount !== 0) begin
         errors++;
         $display("FAIL multi_pulse got %0d errs %0d valids exp 1 and 0", ecount, vcount);
      end
      key_raw = 8'h00;
      for (int i = 0; i < 12; i++) tick();
      key_raw = 8'h02;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         got = sym_valid;
      end
      checks++;
      if (!got || o_vec !== 8'h02) begin
         errors++;
         $display("FAIL multi_next got vld=%b sym=%h exp 1/02", got, o_vec);
      end
      sym_ready = 1'b1;
      tick();
      sym_ready = 1'b0; key_raw = 8'h00;
      for (int i = 0; i < 12; i++) tick();
   endtask

   task automatic test_handshake();
      int   vcount, bad;
      logic got;
      vcount = 0; bad = 0; got = 1'b0;
      key_raw = 8'h10; sym_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (sym_valid) vcount++;
      end
      checks++;
      if (vcount !== 1) begin
         errors++;
         $display("FAIL ready_high got %0d valid cycles exp 1", vcount);
      end
      key_raw = 8'h00;
      for (int i = 0; i < 12; i++) tick();
      sym_ready = 1'b0; key_raw = 8'h01;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         got = sym_valid;
      end
      checks++;
      if (!got || o_vec !== 8'h01) begin
         errors++;
         $display("FAIL offer_key0 got vld=%b sym=%h exp 1/01", got, o_vec);
      end
      key_raw = 8'h09;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (sym_valid !== 1'b1 || o_vec !== 8'h01 || multi_err !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL offer_hold got %0d disturbed cycles exp 0", bad);
      end
      sym_ready = 1'b1;
      tick();
      sym_ready = 1'b0;
      vcount = 0;
      for (int i = 0; i < 47; i++) begin
         key_raw = (i < 20) ? 8'h09 : (i < 35) ? 8'h08 : 8'h00;
         tick();
         if (sym_valid || multi_err) vcount++;
         checks++;
         if ({multi_err, sym_valid, o_vec} !== {m_err, m_valid, m_sym}) begin
            errors++;
            $display("FAIL drain_model got %b/%b/%h exp %b/%b/%h", multi_err, sym_valid, o_vec, m_err, m_valid, m_sym);
         end
      end
      checks++;
      if (vcount !== 0) begin
         errors++;
         $display("FAIL drain_no_symbol got %0d active cycles exp 0", vcount);
      end
   endtask

   task automatic test_reset_mid_offer();
      logic got, ev;
      got = 1'b0;
      key_raw = 8'h80; sym_ready = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         got = sym_valid;
      end
      checks++;
      if (!got || o_vec !== 8'h80) begin
         errors++;
         $display("FAIL rst_offer_setup got vld=%b sym=%h exp 1/80", got, o_vec);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if ({multi_err, sym_valid, o_vec} !== 10'h000) begin
         errors++;
         $display("FAIL rst_offer_clear got err=%b vld=%b sym=%h exp all 0", multi_err, sym_valid, o_vec);
      end
      for (int i = 0; i <= 6; i++) begin
         tick();
         ev = (i == 6);
         checks++;
         if (sym_valid !== ev || o_vec !== (ev ? 8'h80 : 8'h00)) begin
            errors++;
            $display("FAIL rst_offer_reissue i=%0d got vld=%b sym=%h exp vld=%b", i, sym_valid, o_vec, ev);
         end
      end
      sym_ready = 1'b1;
      tick();
      sym_ready = 1'b0; key_raw = 8'h00;
      for (int i = 0; i < 12; i++) tick();
   endtask

   task automatic test_random();
      logic [7:0] pat;
      int         len;
      pat = 8'h00;
      for (int b = 0; b < 80; b++) begin
         case ($urandom_range(0, 3))
            0:       pat = 8'h00;
            1:       pat = 8'h01 << $urandom_range(0, 7);
            2:       pat = 8'($urandom_range(0, 255));
            default: pat = pat ^ (8'h01 << $urandom_range(0, 7));
         endcase
         len = $urandom_range(1, 12);
         for (int c = 0; c < len; c++) begin
            key_raw   = pat;
            sym_ready = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if ({multi_err, sym_valid, o_vec} !== {m_err, m_valid, m_sym}) begin
               errors++;
               $display("FAIL random_model got %b/%b/%h exp %b/%b/%h", multi_err, sym_valid, o_vec, m_err, m_valid, m_sym);
            end
            checks++;
            if (sym_valid ? ($countones(o_vec) != 1) : (o_vec != 8'h00)) begin
               errors++;
               $display("FAIL random_onehot got vld=%b sym=%h", sym_valid, o_vec);
            end
         end
      end
      key_raw = 8'h00; sym_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; key_raw = 8'h08; sym_ready = 1'b0;
      test_reset();
      test_single_press();
      test_bounce();
      test_multi();
      test_handshake();
      test_reset_mid_offer();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
